// File: rtl/scan_mux.sv
// scan_mux: registered N-to-1 multiplexer (N = 2**SW) of W-bit channels with a
// valid/ready output handshake and two select modes: direct (S picks the
// channel) and auto-scan (an internal channel counter walks the channels).
// Channel selection is a one-hot decode of the selected index, ANDed with each
// channel and OR-reduced per bit.
//
// Optional build macro SCAN_MASK_EN: adds input M (one bit per channel). In
// scan mode the counter skips channels whose M bit is clear. If M is all zero,
// nothing is captured in scan mode.
module scan_mux #(
  parameter int SW = 5,
  parameter int W  = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [(1<<SW)*W-1:0]   I,
  input  logic [SW-1:0]          S,
  input  logic                   MODE,
  input  logic                   LD,
  input  logic                   EN,
`ifdef SCAN_MASK_EN
  input  logic [(1<<SW)-1:0]     M,
`endif
  output logic [W-1:0]           Y,
  output logic [SW-1:0]          CH,
  output logic                   Y_VALID,
  input  logic                   Y_READY
);

  localparam int N = 1 << SW;

  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic [SW-1:0] sel;
  logic [SW-1:0] sel_inc;
  logic          sel_ok;
  logic [N-1:0]  dec;
  logic [W-1:0]  mux_y;
  logic          xfer;
  logic          free;
  logic          cap;

`ifdef SCAN_MASK_EN
  logic [SW-1:0] idx;

  // Pick the selected channel; in scan mode, search circularly from the counter
  // for the first unmasked channel (descending loop so the nearest one wins).
  always_comb begin
    sel    = S;
    sel_ok = 1'b1;
    idx    = '0;
    if (!LD && MODE) begin
      sel    = cnt_q;
      sel_ok = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        idx = cnt_q + SW'(i);
        if (M[idx]) begin
          sel    = idx;
          sel_ok = 1'b1;
        end
      end
    end
  end
`else
  // Pick the selected channel: a load or direct mode uses S, scan uses the counter.
  always_comb begin
    sel    = S;
    sel_ok = 1'b1;
    if (!LD && MODE) begin
      sel = cnt_q;
    end
  end
`endif

  assign sel_inc = sel + SW'(1);

  // One-hot decode of the selected index; exactly one bit is ever high.
  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

  // AND each channel with its decoder line and OR-reduce into the mux output.
  always_comb begin
    mux_y = '0;
    for (int k = 0; k < N; k++) begin
      mux_y = mux_y | (I[k*W +: W] & {W{dec[k]}});
    end
  end

  assign xfer = valid_q & Y_READY;
  assign free = ~valid_q | xfer;
  assign cap  = EN & free & sel_ok;

  // Next-state for the output register and the scan counter.
  always_comb begin
    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (cap) begin
      y_d     = mux_y;
      ch_d    = sel;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // A load always wins; otherwise only a scan-mode capture advances the
    // counter, to one past the channel just taken (wrapping modulo N).
    if (LD && cap) begin
      cnt_d = sel_inc;
    end else if (LD) begin
      cnt_d = S;
    end else if (MODE && cap) begin
      cnt_d = sel_inc;
    end
  end

  // State registers with synchronous reset that overrides any stall or scan.
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Y       = y_q;
  assign CH      = ch_q;
  assign Y_VALID = valid_q;

endmodule
